pattern_demod: RTL

Receive-side counterpart of the switcher pattern generator. It recovers a REG_SIZE-bit on/off pattern from a per-cycle activity sensor value, such as an RO-derived count. Each bit slot lasts PERIOD clocks: the block integrates sample_in over the slot, compares the sum against a threshold, and shifts the resulting bit into a recovered-pattern register. It sits beside the switcher and feeds the SPA capture/readout logic.

---
 rtl/pattern_demod.sv | 100 ++++++++++
 1 files changed

// File: rtl/pattern_demod.sv
// Recovers a REG_SIZE-bit on/off pattern from a per-cycle activity sample.
// Each PERIOD-clock slot is integrated and thresholded into one bit, first slot in the MSB.
module pattern_demod #(
    parameter int REG_SIZE = 5,
    parameter int PERIOD   = 10,
    parameter int SAMPLE_W = 4,
    localparam int ACC_W   = SAMPLE_W + $clog2(PERIOD + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic [ACC_W-1:0]    threshold,
    output logic [REG_SIZE-1:0] bits_out,
    output logic                bit_valid,
    output logic                busy,
    output logic                done
);

    localparam int WIN_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int BIT_W = (REG_SIZE > 1) ? $clog2(REG_SIZE) : 1;
    localparam logic [WIN_W-1:0] LAST_WIN = WIN_W'(PERIOD - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(REG_SIZE - 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    // Kept as a named enum so checkers can bind to the FSM state directly.
    state_t              state;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    thr_q;
    logic [WIN_W-1:0]    win_cnt;
    logic [BIT_W-1:0]    bit_cnt;

    logic [ACC_W-1:0]    acc_next;
    logic                dec_bit;
    logic [REG_SIZE-1:0] shifted;

    // acc holds at most (PERIOD-1) full-scale samples, so adding one more fits ACC_W.
    assign acc_next = acc + ACC_W'(sample_in);
    assign dec_bit  = (acc_next > thr_q);

    generate
        if (REG_SIZE == 1) begin : g_single
            assign shifted = dec_bit;
        end else begin : g_multi
            assign shifted = {bits_out[REG_SIZE-2:0], dec_bit};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bits_out  <= '0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            acc       <= '0;
            thr_q     <= '0;
            win_cnt   <= '0;
            bit_cnt   <= '0;
        end else begin
            bit_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        state    <= ACCUM;
                        thr_q    <= threshold;
                        acc      <= '0;
                        win_cnt  <= '0;
                        bit_cnt  <= '0;
                        bits_out <= '0;
                        busy     <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (win_cnt == LAST_WIN) begin
                        bits_out  <= shifted;
                        bit_valid <= 1'b1;
                        acc       <= '0;
                        win_cnt   <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            bit_cnt <= '0;
                            state   <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        acc     <= acc_next;
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
